// File: rtl/winograd_transform_engine.sv
// Winograd input-tile transform Y = B^T.d.B for F(2,3) (4x4) and F(4,3) (6x6) tiles.
// Two passes of one row per cycle share a single shift-and-add row datapath.
module winograd_transform_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = DATA_WIDTH + 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] tile_in  [6][6],
  output logic signed [OUT_WIDTH-1:0]  tile_out [6][6],
  output logic                         busy,
  output logic                         transform_done,
  output logic [1:0]                   state_dbg
);

  // Handshake: start is a level request sampled only in IDLE; the accepting edge
  // raises busy, the edge entering DONE drops busy and raises transform_done for
  // exactly one cycle. Requests seen in any other state are dropped, not queued.

  localparam int TW = DATA_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t                        state;
  logic [2:0]                    r;
  logic [2:0]                    last_r;
  logic                          mode_q;
  logic signed [DATA_WIDTH-1:0]  d_q     [6][6];
  logic signed [TW-1:0]          t_q     [6][6];
  logic signed [OUT_WIDTH-1:0]   sum_row [6];
  logic signed [OUT_WIDTH-1:0]   opnd;
  logic [3:0]                    cf;

  assign state_dbg = state;
  assign last_r    = mode_q ? 3'd5 : 3'd3;

  // B^T coefficient (two's complement nibble); zero outside the 4x4 core in mode 0.
  function automatic logic [3:0] coef(input logic m, input logic [2:0] i, input logic [2:0] j);
    logic [23:0] row;
    logic [3:0]  c;
    row = '0;
    if (m) begin
      case (i)
        3'd0:    row = 24'h40B010;
        3'd1:    row = 24'h0CC110;
        3'd2:    row = 24'h04CF10;
        3'd3:    row = 24'h0EF210;
        3'd4:    row = 24'h02FE10;
        3'd5:    row = 24'h040B01;
        default: row = '0;
      endcase
    end else begin
      case (i)
        3'd0:    row = 24'h10F000;
        3'd1:    row = 24'h011000;
        3'd2:    row = 24'h0F1000;
        3'd3:    row = 24'h010F00;
        default: row = '0;
      endcase
    end
    case (j)
      3'd0:    c = row[23:20];
      3'd1:    c = row[19:16];
      3'd2:    c = row[15:12];
      3'd3:    c = row[11:8];
      3'd4:    c = row[7:4];
      3'd5:    c = row[3:0];
      default: c = '0;
    endcase
    return c;
  endfunction

  // Constant scaling restricted to the coefficient set {0,+-1,+-2,+-4,-5}.
  function automatic logic signed [OUT_WIDTH-1:0] scale(input logic signed [OUT_WIDTH-1:0] x,
                                                        input logic [3:0] c);
    logic signed [OUT_WIDTH-1:0] s;
    case (c)
      4'h1:    s = x;
      4'h2:    s = x <<< 1;
      4'h4:    s = x <<< 2;
      4'hF:    s = -x;
      4'hE:    s = -(x <<< 1);
      4'hC:    s = -(x <<< 2);
      4'hB:    s = -((x <<< 2) + x);
      default: s = '0;
    endcase
    return s;
  endfunction

  // PASS1: column c of row r of T = sum_k BT[r][k]*d[k][c].
  // PASS2: column c of row r of Y = sum_k T[r][k]*BT[c][k].
  always_comb begin
    opnd = '0;
    cf   = '0;
    for (int c = 0; c < 6; c++) begin
      sum_row[c] = '0;
      for (int k = 0; k < 6; k++) begin
        if (state == PASS2) begin
          opnd = t_q[r][k];
          cf   = coef(mode_q, 3'(c), 3'(k));
        end else begin
          opnd = d_q[k][c];
          cf   = coef(mode_q, r, 3'(k));
        end
        sum_row[c] = sum_row[c] + scale(opnd, cf);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      r              <= '0;
      mode_q         <= 1'b0;
      busy           <= 1'b0;
      transform_done <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          d_q[i][j]      <= '0;
          t_q[i][j]      <= '0;
          tile_out[i][j] <= '0;
        end
      end
    end else begin
      transform_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 6; i++) begin
              for (int j = 0; j < 6; j++) begin
                d_q[i][j] <= tile_in[i][j];
              end
            end
            mode_q <= mode;
            busy   <= 1'b1;
            r      <= '0;
            state  <= PASS1;
          end
        end
        PASS1: begin
          for (int c = 0; c < 6; c++) begin
            t_q[r][c] <= sum_row[c][TW-1:0];
          end
          if (r == last_r) begin
            r     <= '0;
            state <= PASS2;
          end else begin
            r <= r + 3'd1;
          end
        end
        PASS2: begin
          for (int c = 0; c < 6; c++) begin
            tile_out[r][c] <= sum_row[c];
          end
          // Rows 4..5 are never reached by the 4-row pass, so clear them up front.
          if (!mode_q && r == 3'd0) begin
            for (int c = 0; c < 6; c++) begin
              tile_out[4][c] <= '0;
              tile_out[5][c] <= '0;
            end
          end
          if (r == last_r) begin
            r              <= '0;
            busy           <= 1'b0;
            transform_done <= 1'b1;
            state          <= DONE;
          end else begin
            r <= r + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_transform_engine.sv
// Randomised bench for winograd_transform_engine against a plain matrix-product model.
module tb_winograd_transform_engine;

  localparam int DW = 16;
  localparam int OW = DW + 8;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 mode;
  logic signed [DW-1:0] tile_in  [6][6];
  logic signed [OW-1:0] tile_out [6][6];
  logic                 busy;
  logic                 transform_done;
  logic [1:0]           state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cyc [$];
  logic [OW-1:0] exp_q [$];

  int     d_ref [6][6];
  longint y_ref [6][6];
  int bt6 [6][6] = '{'{4, 0, -5, 0, 1, 0}, '{0, -4, -4, 1, 1, 0}, '{0, 4, -4, -1, 1, 0},
                     '{0, -2, -1, 2, 1, 0}, '{0, 2, -1, -2, 1, 0}, '{0, 4, 0, -5, 0, 1}};
  int bt4 [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};

  winograd_transform_engine #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .tile_in        (tile_in),
    .tile_out       (tile_out),
    .busy           (busy),
    .transform_done (transform_done),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cyc++;
    if (transform_done === 1'b1) done_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int bt(input bit m, input int i, input int k);
    if (m) return bt6[i][k];
    if (i < 4 && k < 4) return bt4[i][k];
    return 0;
  endfunction

  task automatic compute_ref(input bit m);
    longint t [6][6];
    int n;
    n = m ? 6 : 4;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        t[i][j]     = 0;
        y_ref[i][j] = 0;
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++)
          t[i][j] += longint'(bt(m, i, k)) * d_ref[k][j];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++)
          y_ref[i][j] += t[i][k] * bt(m, j, k);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        exp_q.push_back(OW'(y_ref[i][j]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_elem(input int i, input int j, input int v);
    tile_in[i][j] = DW'(v);
    d_ref[i][j]   = v;
  endtask

  task automatic clear_tile();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) set_elem(i, j, 0);
  endtask

  task automatic load_random();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) set_elem(i, j, int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) tile_in[i][j] = DW'($urandom_range(0, 65535));
  endtask

  task automatic do_start(input bit m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    compute_ref(m);
  endtask

  // Counts edges from the accepting edge until transform_done, then one more edge.
  task automatic run_to_done(input int elapsed, input bit poke, output int lat,
                             output bit busy_at_done, output bit done_after);
    lat = elapsed;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (transform_done === 1'b1) break;
    end
    busy_at_done = busy;
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    done_after = transform_done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nz;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    clear_tile();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (transform_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", transform_done); end
    nz = 0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) if (tile_out[i][j] !== '0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL reset_tile nonzero elements got %0d want 0", nz); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int lat; bit bd, da; logic [OW-1:0] e;
    clear_tile();
    set_elem(2, 2, 1);
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL impulse_busy got %b want 1", busy); end
    run_to_done(0, 1'b0, lat, bd, da);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL impulse_latency got %0d want 12", lat); end
    checks++;
    if (bd !== 1'b0) begin errors++; $display("FAIL impulse_busy_done got %b want 0", bd); end
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL impulse_done_width got %b want 0", da); end
    checks++;
    if ($signed(tile_out[0][0]) != 25 || $signed(tile_out[0][1]) != 20 || $signed(tile_out[1][1]) != 16 ||
        $signed(tile_out[3][3]) != 1 || $signed(tile_out[0][3]) != 5 || $signed(tile_out[5][2]) != 0)
    begin
      errors++;
      $display("FAIL impulse_spot got %0d %0d %0d %0d %0d %0d want 25 20 16 1 5 0",
               $signed(tile_out[0][0]), $signed(tile_out[0][1]), $signed(tile_out[1][1]),
               $signed(tile_out[3][3]), $signed(tile_out[0][3]), $signed(tile_out[5][2]));
    end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (tile_out[i][j] !== e) begin
          errors++;
          $display("FAIL impulse_tile Y[%0d][%0d] got %0d want %0d", i, j, $signed(tile_out[i][j]), $signed(e));
        end
      end
  endtask

  task automatic test_all_ones();
    int lat; bit bd, da; logic [OW-1:0] e;
    for (int m = 1; m >= 0; m--) begin
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) set_elem(i, j, 1);
      do_start(m[0]);
      run_to_done(0, 1'b0, lat, bd, da);
      checks++;
      if (lat != (m == 1 ? 12 : 8)) begin
        errors++;
        $display("FAIL ones_latency mode %0d got %0d want %0d", m, lat, (m == 1 ? 12 : 8));
      end
      checks++;
      if ($signed(tile_out[1][1]) != (m == 1 ? 36 : 4)) begin
        errors++;
        $display("FAIL ones_y11 mode %0d got %0d want %0d", m, $signed(tile_out[1][1]), (m == 1 ? 36 : 4));
      end
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          e = exp_q.pop_front();
          checks++;
          if (tile_out[i][j] !== e) begin
            errors++;
            $display("FAIL ones_tile mode %0d Y[%0d][%0d] got %0d want %0d", m, i, j,
                     $signed(tile_out[i][j]), $signed(e));
          end
        end
    end
  endtask

  task automatic test_min_value();
    int lat; bit bd, da; logic [OW-1:0] e;
    clear_tile();
    set_elem(2, 2, -32768);
    do_start(1'b1);
    run_to_done(0, 1'b0, lat, bd, da);
    checks++;
    if ($signed(tile_out[0][0]) != -819200 || $signed(tile_out[1][1]) != -524288 ||
        $signed(tile_out[3][4]) != -32768) begin
      errors++;
      $display("FAIL minval_spot got %0d %0d %0d want -819200 -524288 -32768",
               $signed(tile_out[0][0]), $signed(tile_out[1][1]), $signed(tile_out[3][4]));
    end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (tile_out[i][j] !== e) begin
          errors++;
          $display("FAIL minval_tile Y[%0d][%0d] got %0d want %0d", i, j, $signed(tile_out[i][j]), $signed(e));
        end
      end
  endtask

  task automatic test_random();
    int lat; bit bd, da; bit m; logic [OW-1:0] e;
    for (int t = 0; t < 8; t++) begin
      m = 1'($urandom_range(0, 1));
      load_random();
      do_start(m);
      run_to_done(0, 1'b0, lat, bd, da);
      checks++;
      if (lat != (m ? 12 : 8)) begin
        errors++;
        $display("FAIL random_latency iter %0d got %0d want %0d", t, lat, (m ? 12 : 8));
      end
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          e = exp_q.pop_front();
          checks++;
          if (tile_out[i][j] !== e) begin
            errors++;
            $display("FAIL random_tile iter %0d mode %0d Y[%0d][%0d] got %0d want %0d", t, m, i, j,
                     $signed(tile_out[i][j]), $signed(e));
          end
        end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit bd, da; int idle_busy; logic [OW-1:0] e;
    done_cyc.delete();
    load_random();
    do_start(1'b1);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    mode  = 1'b0;
    scramble_inputs();
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    run_to_done(3, 1'b1, lat, bd, da);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL ignore_latency got %0d want 12", lat); end
    idle_busy = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) idle_busy++;
    end
    checks++;
    if (idle_busy != 0) begin errors++; $display("FAIL ignore_done_start busy cycles got %0d want 0", idle_busy); end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", done_cyc.size()); end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (tile_out[i][j] !== e) begin
          errors++;
          $display("FAIL ignore_tile Y[%0d][%0d] got %0d want %0d", i, j, $signed(tile_out[i][j]), $signed(e));
        end
      end
  endtask

  task automatic test_reset_mid();
    int lat; bit bd, da; int nz; logic [OW-1:0] e;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) set_elem(i, j, i * 6 + j + 1);
    do_start(1'b1);
    repeat (8) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) if (tile_out[i][j] !== '0) nz++;
    checks++;
    if (nz != 0 || busy !== 1'b0 || transform_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs nonzero %0d busy %b done %b want 0 0 0", nz, busy, transform_done);
    end
    exp_q.delete();
    done_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc.size() != 0) begin errors++; $display("FAIL midreset_pulse got %0d want 0", done_cyc.size()); end
    do_start(1'b1);
    run_to_done(0, 1'b0, lat, bd, da);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL midreset_latency got %0d want 12", lat); end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (tile_out[i][j] !== e) begin
          errors++;
          $display("FAIL midreset_tile Y[%0d][%0d] got %0d want %0d", i, j, $signed(tile_out[i][j]), $signed(e));
        end
      end
  endtask

  // Starts land in the IDLE cycle right after DONE: accept-to-accept is 2N+2,
  // so done-to-done is 14 into a mode-1 job and 10 into a mode-0 job.
  task automatic test_back_to_back();
    int lat; bit bd, da; logic [OW-1:0] e;
    bit modes [3] = '{1'b1, 1'b1, 1'b0};
    done_cyc.delete();
    for (int t = 0; t < 3; t++) begin
      load_random();
      do_start(modes[t]);
      run_to_done(0, 1'b0, lat, bd, da);
      checks++;
      if (lat != (modes[t] ? 12 : 8)) begin
        errors++;
        $display("FAIL b2b_latency job %0d got %0d want %0d", t, lat, (modes[t] ? 12 : 8));
      end
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          e = exp_q.pop_front();
          checks++;
          if (tile_out[i][j] !== e) begin
            errors++;
            $display("FAIL b2b_tile job %0d Y[%0d][%0d] got %0d want %0d", t, i, j,
                     $signed(tile_out[i][j]), $signed(e));
          end
        end
    end
    checks++;
    if (done_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 3", done_cyc.size());
    end else begin
      checks++;
      if (done_cyc[1] - done_cyc[0] != 14 || done_cyc[2] - done_cyc[1] != 10) begin
        errors++;
        $display("FAIL b2b_spacing got %0d %0d want 14 10", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_all_ones();
    test_min_value();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
